trace_line_arbiter: RTL

//  Shares one cpu_checker among NUM_SRC trace-character sources. Grants one source per

---
 rtl/trace_line_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/trace_line_arbiter.sv
// trace_line_arbiter: round-robin share of one cpu_checker among NUM_SRC trace sources, one whole line ('^'..'#') per grant.
// Latency: chars reach chk_char combinationally in the cycle they are accepted; res_valid pulses 2 cycles after the '#' edge.
// Backpressure: src_ready is combinational; only the granted source is served mid-line; no source is ready during RESULT/ABORT/reset.
//
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-high reset
//   src_valid/src_char/src_ready per-source char stream, char i at src_char[8i+7:8i]
//   chk_char/chk_reset          char and sync reset driven to the checker
//   chk_format_type             checker result, sampled in the RESULT cycle
//   grant_src, busy             locked source and line-in-progress flag
//   res_valid/src/type/abort    one-cycle per-line result
// Optional (macro TRACE_ARB_STATS_EN): stat_sel, stat_clr in; stat_ok, stat_abort out
//   (per-source saturating counts of typed lines and aborted lines).
module trace_line_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2,
    parameter int MAX_LEN = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [8*NUM_SRC-1:0] src_char,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic [7:0]           chk_char,
    output logic                 chk_reset,
    input  logic [1:0]           chk_format_type,
    output logic [SRC_W-1:0]     grant_src,
    output logic                 busy,
    output logic                 res_valid,
    output logic [SRC_W-1:0]     res_src,
    output logic [1:0]           res_type,
    output logic                 res_abort
`ifdef TRACE_ARB_STATS_EN
    ,
    input  logic [SRC_W-1:0]     stat_sel,
    input  logic                 stat_clr,
    output logic [15:0]          stat_ok,
    output logic [15:0]          stat_abort
`endif
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [7:0] CH_START = 8'h5E;  // '^'
    localparam logic [7:0] CH_END   = 8'h23;  // '#'

    typedef enum logic [1:0] {IDLE, LOCK, RESULT, ABORT} state_t;

    state_t           state, state_nxt;
    logic [SRC_W-1:0] rr_ptr, rr_nxt, grant_nxt, winner;
    logic [LEN_W-1:0] len, len_nxt;
    logic             found;
    logic [SRC_W:0]   cand;
    logic [7:0]       win_char, gnt_char;

    function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] s);
        if (s == SRC_W'(NUM_SRC - 1)) return '0;
        return s + SRC_W'(1);
    endfunction

    // First valid source at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = {1'b0, rr_ptr} + (SRC_W+1)'(i);
            if (cand >= (SRC_W+1)'(NUM_SRC)) cand = cand - (SRC_W+1)'(NUM_SRC);
            if (!found && src_valid[cand[SRC_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[SRC_W-1:0];
            end
        end
    end

    assign win_char = src_char[{winner, 3'b000} +: 8];
    assign gnt_char = src_char[{grant_src, 3'b000} +: 8];

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        rr_nxt    = rr_ptr;
        grant_nxt = grant_src;
        src_ready = '0;
        chk_char  = 8'h00;
        case (state)
            IDLE: begin
                if (found) begin
                    src_ready[winner] = 1'b1;
                    if (win_char == CH_START) begin
                        chk_char  = CH_START;
                        grant_nxt = winner;
                        len_nxt   = LEN_W'(1);
                        state_nxt = LOCK;
                    end else begin
                        // Stray char outside a line: consume and discard it, and
                        // move the pointer on so a noisy source cannot starve others.
                        rr_nxt = next_src(winner);
                    end
                end
            end
            LOCK: begin
                if (src_valid[grant_src]) begin
                    src_ready[grant_src] = 1'b1;
                    chk_char = gnt_char;
                    if (gnt_char == CH_END) begin
                        len_nxt   = len + LEN_W'(1);
                        state_nxt = RESULT;
                    end else if (gnt_char == CH_START) begin
                        // Checker restarts on '^' by itself; only the length restarts here.
                        len_nxt = LEN_W'(1);
                    end else begin
                        len_nxt = len + LEN_W'(1);
                        // The char that brings len to MAX_LEN is not '#': no room left.
                        if (len == LEN_W'(MAX_LEN - 1)) state_nxt = ABORT;
                    end
                end else begin
                    state_nxt = ABORT;  // gap mid-line
                end
            end
            RESULT, ABORT: begin
                rr_nxt    = next_src(grant_src);
                len_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            src_ready = '0;
            chk_char  = 8'h00;
        end
    end

    assign busy      = (state != IDLE);
    assign chk_reset = reset | (state == ABORT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            len       <= '0;
            grant_src <= '0;
            res_valid <= 1'b0;
            res_src   <= '0;
            res_type  <= 2'b00;
            res_abort <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            len       <= len_nxt;
            grant_src <= grant_nxt;
            res_valid <= 1'b0;
            if (state == RESULT) begin
                res_valid <= 1'b1;
                res_src   <= grant_src;
                res_type  <= chk_format_type;
                res_abort <= 1'b0;
            end else if (state == ABORT) begin
                res_valid <= 1'b1;
                res_src   <= grant_src;
                res_type  <= 2'b00;
                res_abort <= 1'b1;
            end
        end
    end

`ifdef TRACE_ARB_STATS_EN
    logic [15:0] ok_cnt    [NUM_SRC];
    logic [15:0] abort_cnt [NUM_SRC];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                ok_cnt[i]    <= '0;
                abort_cnt[i] <= '0;
            end
        end else if (stat_clr) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                ok_cnt[i]    <= '0;
                abort_cnt[i] <= '0;
            end
        end else begin
            if (state == RESULT && chk_format_type != 2'b00 && ok_cnt[grant_src] != 16'hFFFF)
                ok_cnt[grant_src] <= ok_cnt[grant_src] + 16'd1;
            if (state == ABORT && abort_cnt[grant_src] != 16'hFFFF)
                abort_cnt[grant_src] <= abort_cnt[grant_src] + 16'd1;
        end
    end

    assign stat_ok    = ok_cnt[stat_sel];
    assign stat_abort = abort_cnt[stat_sel];
`endif

endmodule
